// File: rtl/dmem_access_ctrl_if.sv
// rtl/dmem_access_ctrl_if.sv - req/ack data-memory port between the MEM-stage controller and memory
interface dmem_access_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - MEM-stage load/store controller with stall, lane steering and ack timeout
// Optional misaligned-access trap: define DMEM_MISALIGN_TRAP_EN.
module dmem_access_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              MemStall,
  output logic [31:0]       load_data,
  output logic              bus_err,
`ifdef DMEM_MISALIGN_TRAP_EN
  output logic              misaligned,
`endif
  dmem_access_ctrl_if.master mem
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t state, state_nx;

  logic             is_mem;
  logic             is_byte, is_half;
  logic [3:0]       be_in;
  logic [31:0]      wdata_in;
  logic             mis_in;
  logic             timeout_hit;

  logic             store_q;
  logic             byte_q, half_q, uns_q;
  logic [1:0]       off_q;
  logic [CNT_W-1:0] cnt;

  logic [7:0]       sel_byte;
  logic [15:0]      sel_half;
  logic [31:0]      load_ext;

  assign is_mem = MemRead | MemWrite;

  // funct3[1:0] alone gives the width; the undefined codes 011/110/111 all fall into "word"
  assign is_byte = (funct3[1:0] == 2'b00);
  assign is_half = (funct3[1:0] == 2'b01);

  always_comb begin
    be_in    = 4'b1111;
    wdata_in = wdata;
    if (is_byte) begin
      be_in    = 4'b0001 << addr[1:0];
      wdata_in = {4{wdata[7:0]}};
    end else if (is_half) begin
      be_in    = addr[1] ? 4'b1100 : 4'b0011;
      wdata_in = {2{wdata[15:0]}};
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  assign mis_in = (is_half & addr[0]) | (!is_byte & !is_half & (addr[1:0] != 2'b00));
`else
  assign mis_in = 1'b0;
`endif

  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (is_mem) state_nx = mis_in ? DONE : REQ;
      REQ:     if (mem.mem_ack || timeout_hit) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    MemStall    = ((state == IDLE) && is_mem) || (state == REQ);
    mem.mem_req = (state == REQ);
    mem.mem_we  = (state == REQ) && store_q;
  end

  always_comb begin
    case (off_q)
      2'd0:    sel_byte = mem.mem_rdata[7:0];
      2'd1:    sel_byte = mem.mem_rdata[15:8];
      2'd2:    sel_byte = mem.mem_rdata[23:16];
      default: sel_byte = mem.mem_rdata[31:24];
    endcase
    sel_half = off_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    if (byte_q)
      load_ext = uns_q ? {24'd0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
    else if (half_q)
      load_ext = uns_q ? {16'd0, sel_half} : {{16{sel_half[15]}}, sel_half};
    else
      load_ext = mem.mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem.mem_addr  <= '0;
      mem.mem_be    <= 4'b0000;
      mem.mem_wdata <= 32'd0;
      load_data     <= 32'd0;
      bus_err       <= 1'b0;
      cnt           <= '0;
      store_q       <= 1'b0;
      byte_q        <= 1'b0;
      half_q        <= 1'b0;
      uns_q         <= 1'b0;
      off_q         <= 2'b00;
`ifdef DMEM_MISALIGN_TRAP_EN
      misaligned    <= 1'b0;
`endif
    end else begin
      bus_err <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
      misaligned <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (is_mem) begin
            store_q       <= MemWrite;
            byte_q        <= is_byte;
            half_q        <= is_half;
            uns_q         <= funct3[2];
            off_q         <= addr[1:0];
            cnt           <= '0;
            mem.mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
            mem.mem_be    <= MemWrite ? be_in : 4'b1111;
            mem.mem_wdata <= MemWrite ? wdata_in : 32'd0;
`ifdef DMEM_MISALIGN_TRAP_EN
            if (mis_in) begin
              misaligned <= 1'b1;
              load_data  <= 32'd0;
            end
`endif
          end
        end
        REQ: begin
          if (mem.mem_ack) begin
            if (!store_q) load_data <= load_ext;
          end else if (timeout_hit) begin
            bus_err   <= 1'b1;
            load_data <= 32'd0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - directed and randomized bench for dmem_access_ctrl against a behavioural model
module tb_dmem_access_ctrl;

  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        MemStall;
  logic [31:0] load_data;
  logic        bus_err;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  dmem_access_ctrl_if #(.ADDR_W(ADDR_W)) mif ();

  dmem_access_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .MemStall  (MemStall),
    .load_data (load_data),
    .bus_err   (bus_err),
`ifdef DMEM_MISALIGN_TRAP_EN
    .misaligned(misaligned),
`endif
    .mem       (mif)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  logic [31:0] model_load = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic int lane_of(input logic [2:0] f3, input logic [31:0] a);
    int n = size_of(f3);
    return (int'(a % 4) / n) * n;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    int n = size_of(f3);
    int lane = lane_of(f3, a);
    logic [31:0] mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    logic [31:0] v = (rd >> (8 * lane)) & mask;
    if (n < 4 && f3[2] == 1'b0 && v[8 * n - 1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int n = size_of(f3);
    if (n == 1) return (wd & 32'hFF) * 32'h0101_0101;
    if (n == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  task automatic do_access(input bit st, input bit rd_too, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdv,
                           input int wait_n, input string nm);
    int n, lane;
    bit mis, tmo;
    logic [31:0] exp_be, exp_addr;
    n = size_of(f3);
    lane = lane_of(f3, a);
    mis = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    mis = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
`endif
    tmo = !mis && (wait_n >= TIMEOUT);
    exp_be = st ? (((32'd1 << n) - 32'd1) << lane) : 32'hF;
    exp_addr = a & ~32'h3;

    @(negedge clk);
    MemWrite = st; MemRead = !st || rd_too;
    funct3 = f3; addr = a; wdata = wd; mif.mem_ack = 1'b0;
    #1;
    check({nm, " stall_idle"}, MemStall, 1);
    check({nm, " req_idle"}, mif.mem_req, 0);

    if (!mis) begin
      for (int i = 0; i < TIMEOUT; i++) begin
        @(negedge clk);
        mif.mem_ack = (i == wait_n);
        mif.mem_rdata = (i == wait_n) ? rdv : $urandom;
        #1;
        check($sformatf("%s stall_req%0d", nm, i), MemStall, 1);
        check($sformatf("%s req%0d", nm, i), mif.mem_req, 1);
        check($sformatf("%s we%0d", nm, i), mif.mem_we, st);
        check($sformatf("%s addr%0d", nm, i), mif.mem_addr, exp_addr);
        check($sformatf("%s be%0d", nm, i), mif.mem_be, exp_be);
        if (st) check($sformatf("%s wdata%0d", nm, i), mif.mem_wdata, ref_wdata(f3, wd));
        if (i == wait_n) break;
      end
    end

    @(negedge clk);
    mif.mem_ack = 1'b0;
    #1;
    if (mis || tmo) model_load = 32'd0;
    else if (!st) model_load = ref_load(f3, a, rdv);
    check({nm, " stall_done"}, MemStall, 0);
    check({nm, " req_done"}, mif.mem_req, 0);
    check({nm, " bus_err"}, bus_err, tmo);
    check({nm, " load_data"}, load_data, model_load);
`ifdef DMEM_MISALIGN_TRAP_EN
    check({nm, " misaligned"}, misaligned, mis);
`endif
  endtask

  task automatic idle_cycle(input string nm);
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0;
    #1;
    check({nm, " idle_stall"}, MemStall, 0);
    check({nm, " idle_req"}, mif.mem_req, 0);
    check({nm, " idle_bus_err"}, bus_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'b010;
    addr = 32'd0; wdata = 32'd0; mif.mem_ack = 1'b0; mif.mem_rdata = 32'd0;

    @(negedge clk); @(negedge clk);
    #1;
    check("rst stall", MemStall, 0);
    check("rst req", mif.mem_req, 0);
    check("rst we", mif.mem_we, 0);
    check("rst addr", mif.mem_addr, 0);
    check("rst be", mif.mem_be, 0);
    check("rst wdata", mif.mem_wdata, 0);
    check("rst load_data", load_data, 0);
    check("rst bus_err", bus_err, 0);

    MemRead = 1'b1;
    #1 check("rst stall_isMem", MemStall, 1);
    @(negedge clk);
    #1 check("rst held_idle", mif.mem_req, 0);
    @(negedge clk);
    reset = 1'b0; MemRead = 1'b0;
    #1 check("post_rst stall", MemStall, 0);

    do_access(0, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, "lw");
    check("lw const", load_data, 32'hDEADBEEF);
    do_access(0, 0, 3'b000, 32'h103, 32'h0, 32'h80123456, 0, "lb");
    check("lb const", load_data, 32'hFFFFFF80);
    do_access(0, 0, 3'b100, 32'h103, 32'h0, 32'h80123456, 0, "lbu");
    check("lbu const", load_data, 32'h00000080);
    do_access(0, 0, 3'b001, 32'h102, 32'h0, 32'h80015A5A, 0, "lh");
    check("lh const", load_data, 32'hFFFF8001);
    idle_cycle("after_loads");

    do_access(1, 0, 3'b000, 32'h201, 32'h000000AB, 32'h0, 0, "sb");
    check("sb keeps load_data", load_data, 32'hFFFF8001);
    do_access(1, 1, 3'b001, 32'h202, 32'h00001234, 32'h0, 0, "sh");
    idle_cycle("after_stores");

    do_access(0, 0, 3'b101, 32'h302, 32'h0, 32'h9ABC1111, 3, "lhu_wait3");
    check("lhu const", load_data, 32'h00009ABC);
    do_access(0, 0, 3'b010, 32'h400, 32'h0, 32'h0, TIMEOUT + 4, "timeout");
    check("timeout load_data", load_data, 32'h0);
    idle_cycle("after_timeout");

    do_access(0, 0, 3'b010, 32'h102, 32'h0, 32'hCAFEF00D, 0, "lw_misalign");
    idle_cycle("after_misalign");

    @(negedge clk);
    MemRead = 1'b1; MemWrite = 1'b0; funct3 = 3'b010; addr = 32'h300;
    @(negedge clk);
    #1 check("mid_rst req_before", mif.mem_req, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; MemRead = 1'b0; mif.mem_ack = 1'b1; mif.mem_rdata = 32'h12345678;
    #1;
    check("mid_rst req", mif.mem_req, 0);
    check("mid_rst stall", MemStall, 0);
    check("mid_rst be", mif.mem_be, 0);
    check("mid_rst addr", mif.mem_addr, 0);
    check("mid_rst load_data", load_data, 0);
    @(negedge clk);
    mif.mem_ack = 1'b0;
    #1;
    check("late_ack req", mif.mem_req, 0);
    check("late_ack stall", MemStall, 0);
    check("late_ack load_data", load_data, 0);
    model_load = 32'd0;

    for (int k = 0; k < 40; k++) begin
      bit st;
      logic [2:0] f3;
      int wn;
      st = ($urandom_range(0, 1) == 1);
      f3 = st ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      wn = ($urandom_range(0, 7) == 0) ? TIMEOUT + 1 : $urandom_range(0, 3);
      do_access(st, ($urandom_range(0, 1) == 1), f3, $urandom, $urandom, $urandom, wn,
                $sformatf("rnd%0d", k));
      if ($urandom_range(0, 2) == 0) idle_cycle($sformatf("rnd%0d", k));
    end
    idle_cycle("end");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
